fifo_param: RTL and testbench

Parametrised, button-driven synchronous FIFO for the board-level demo designs: each press of a push button performs exactly one write or read, selected by a switch. It adds configurable width and depth, occupancy count, programmable almost-full/almost-empty thresholds, and sticky overflow/underflow flags. It drives the head word onto four seven-segment displays, and sits between board switches/buttons and the hex display drivers.

---
 rtl/fifo_param.sv | 186 ++++++++++++++++++
 tb/tb_fifo_param.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_param.sv
// Button-driven parametrised FIFO: one push or pop per button press, with status flags and hex display.
// Optional macro FIFO_DEBOUNCE_EN adds a press/release debounce counter ahead of the op pulse.
module fifo_param #(
  parameter int WIDTH           = 16,
  parameter int DEPTH           = 8,
  parameter int AF_LEVEL        = 6,
  parameter int AE_LEVEL        = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     button,
  input  logic                     wren,
  input  logic [WIDTH-1:0]         dataIn,
  output logic [WIDTH-1:0]         dataOut,
  output logic [6:0]               dataHex0,
  output logic [6:0]               dataHex1,
  output logic [6:0]               dataHex2,
  output logic [6:0]               dataHex3,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     almostFull,
  output logic                     almostEmpty,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

  logic       sync1_q, sync2_q;
  logic [1:0] fill_q;
  logic       sample_valid;
  logic       armed_q;
  logic       op;

  // sync2_q only holds a genuine button sample once two edges have passed since reset.
  assign sample_valid = (fill_q == 2'd2);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      fill_q  <= 2'd0;
    end else begin
      sync1_q <= button;
      sync2_q <= sync1_q;
      if (!sample_valid) fill_q <= fill_q + 2'd1;
    end
  end

`ifdef FIFO_DEBOUNCE_EN
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DW-1:0] DB_C = DW'(DEBOUNCE_CYCLES);
  logic [DW-1:0] db_cnt_q;

  assign op = armed_q && !sync2_q && (db_cnt_q == DB_C);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      armed_q  <= 1'b0;
      db_cnt_q <= '0;
    end else if (sample_valid) begin
      if (armed_q) begin
        if (op) begin
          armed_q  <= 1'b0;
          db_cnt_q <= '0;
        end else if (sync2_q) db_cnt_q <= '0;
        else                  db_cnt_q <= db_cnt_q + DW'(1);
      end else begin
        if (!sync2_q) db_cnt_q <= '0;
        else if (db_cnt_q == DB_C - DW'(1)) begin
          armed_q  <= 1'b1;
          db_cnt_q <= '0;
        end else db_cnt_q <= db_cnt_q + DW'(1);
      end
    end
  end
`else
  logic prev_q;

  assign op = armed_q && prev_q && !sync2_q;

  // A button held through reset release never arms, so it cannot fire an op.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      prev_q  <= 1'b1;
      armed_q <= 1'b0;
    end else begin
      prev_q <= sync2_q;
      if (sample_valid && sync2_q) armed_q <= 1'b1;
    end
  end
`endif

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             full_q, empty_q, af_q, ae_q, ovf_q, unf_q;
  logic             do_write, do_read;

  assign do_write = op && wren && !full_q;
  assign do_read  = op && !wren && !empty_q;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_write) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
      count_d  = count_q + CW'(1);
    end
    if (do_read) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
      count_d  = count_q - CW'(1);
    end
  end

  // NOTE: state updates use non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      af_q     <= 1'b0;
      ae_q     <= 1'b1;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= (count_d == DEPTH_C);
      empty_q  <= (count_d == '0);
      af_q     <= (count_d >= AF_C);
      ae_q     <= (count_d <= AE_C);
      if (op && wren && full_q)   ovf_q <= 1'b1;
      if (op && !wren && empty_q) unf_q <= 1'b1;
    end
  end

  // NOTE: storage has no reset; emptiness is tracked by count, so stale words are never shown.
  always_ff @(posedge clock) begin
    if (do_write) mem[wr_ptr_q] <= dataIn;
  end

  assign dataOut     = empty_q ? '0 : mem[rd_ptr_q];
  assign count       = count_q;
  assign full        = full_q;
  assign empty       = empty_q;
  assign almostFull  = af_q;
  assign almostEmpty = ae_q;
  assign overflow    = ovf_q;
  assign underflow   = unf_q;

  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'h0: seg7 = 7'h40;  4'h1: seg7 = 7'h79;  4'h2: seg7 = 7'h24;  4'h3: seg7 = 7'h30;
      4'h4: seg7 = 7'h19;  4'h5: seg7 = 7'h12;  4'h6: seg7 = 7'h02;  4'h7: seg7 = 7'h78;
      4'h8: seg7 = 7'h00;  4'h9: seg7 = 7'h10;  4'hA: seg7 = 7'h08;  4'hB: seg7 = 7'h03;
      4'hC: seg7 = 7'h46;  4'hD: seg7 = 7'h21;  4'hE: seg7 = 7'h06;  default: seg7 = 7'h0E;
    endcase
  endfunction

  logic [15:0] hex_word;
  generate
    if (WIDTH >= 16) begin : g_hex_trunc
      assign hex_word = dataOut[15:0];
    end else begin : g_hex_pad
      assign hex_word = {{(16-WIDTH){1'b0}}, dataOut};
    end
  endgenerate

  assign dataHex0 = empty_q ? 7'h7F : seg7(hex_word[3:0]);
  assign dataHex1 = empty_q ? 7'h7F : seg7(hex_word[7:4]);
  assign dataHex2 = empty_q ? 7'h7F : seg7(hex_word[11:8]);
  assign dataHex3 = empty_q ? 7'h7F : seg7(hex_word[15:12]);

endmodule

// File: tb/tb_fifo_param.sv
// Randomised bench for fifo_param against a queue-based reference model of the FIFO.
// Define FIFO_DEBOUNCE_EN on both files to exercise the debounce scenario.
module tb_fifo_param;

  logic        clock = 1'b0;
  logic        reset_n, button, wren;
  logic [15:0] dataIn, dataOut;
  logic [6:0]  dataHex0, dataHex1, dataHex2, dataHex3;
  logic [3:0]  count;
  logic        full, empty, almostFull, almostEmpty, overflow, underflow;

  int vectors = 0;
  int miscompares = 0;

`ifdef FIFO_DEBOUNCE_EN
  localparam int PRESS_LO = 7;
  localparam int PRESS_HI = 8;
`else
  localparam int PRESS_LO = 3;
  localparam int PRESS_HI = 3;
`endif

  always #5 clock = ~clock;

  fifo_param #(.WIDTH(16), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(2), .DEBOUNCE_CYCLES(4)) dut (
    .clock(clock), .reset_n(reset_n), .button(button), .wren(wren), .dataIn(dataIn),
    .dataOut(dataOut), .dataHex0(dataHex0), .dataHex1(dataHex1), .dataHex2(dataHex2),
    .dataHex3(dataHex3), .count(count), .full(full), .empty(empty),
    .almostFull(almostFull), .almostEmpty(almostEmpty), .overflow(overflow), .underflow(underflow)
  );

  logic [15:0] q[$];
  logic        m_ovf, m_unf;
  logic [6:0]  glyphs [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  task automatic model_apply(input logic wr, input logic [15:0] d);
    if (wr) begin
      if (q.size() == 8) m_ovf = 1'b1;
      else q.push_back(d);
    end else begin
      if (q.size() == 0) m_unf = 1'b1;
      else void'(q.pop_front());
    end
  endtask

  function automatic logic [15:0] exp_data();
    return (q.size() == 0) ? 16'h0 : q[0];
  endfunction

  function automatic logic [6:0] exp_hex(input int i);
    logic [15:0] w;
    w = exp_data();
    return (q.size() == 0) ? 7'h7F : glyphs[w[4*i +: 4]];
  endfunction

  function automatic logic [3:0] exp_count();
    return 4'(q.size());
  endfunction

  // One complete press starting and ending on a falling clock edge.
  task automatic press(input logic wr, input logic [15:0] d, input int lo);
    wren = wr; dataIn = d; button = 1'b0;
    repeat (lo) @(negedge clock);
    button = 1'b1;
    repeat (PRESS_HI) @(negedge clock);
    model_apply(wr, d);
  endtask

  task automatic test_reset();
    reset_n = 1'b0; button = 1'b1; wren = 1'b0; dataIn = '0;
    q.delete(); m_ovf = 1'b0; m_unf = 1'b0;
    repeat (3) @(negedge clock);
    vectors++;
    if ({count, empty, almostEmpty, full, almostFull, overflow, underflow} !== {4'd0, 6'b110000}) begin
      miscompares++;
      $display("FAIL reset_flags: got cnt=%0d e=%b ae=%b f=%b af=%b ov=%b un=%b, want 0 1 1 0 0 0 0",
               count, empty, almostEmpty, full, almostFull, overflow, underflow);
    end
    vectors++;
    if ({dataOut, dataHex0, dataHex1, dataHex2, dataHex3} !== {16'h0, {4{7'h7F}}}) begin
      miscompares++;
      $display("FAIL reset_display: got %h %h %h %h %h, want 0000 7f x4", dataOut, dataHex0, dataHex1, dataHex2, dataHex3);
    end
    reset_n = 1'b1;
    repeat (PRESS_HI + 4) @(negedge clock);
    press(1'b1, 16'hA5A5, PRESS_LO);
    vectors++;
    if (count !== 4'd1 || dataHex0 !== 7'h12) begin
      miscompares++;
      $display("FAIL reset_prewrite: got cnt=%0d hex0=%h, want 1 12", count, dataHex0);
    end
    // Reset lands while a write press is held; the press stays held past release.
    wren = 1'b1; dataIn = 16'h3333; button = 1'b0;
    @(posedge clock); #2 reset_n = 1'b0; #1;
    q.delete(); m_ovf = 1'b0; m_unf = 1'b0;
    vectors++;
    if (empty !== 1'b1 || count !== 4'd0 || {dataHex0, dataHex1, dataHex2, dataHex3} !== {4{7'h7F}}) begin
      miscompares++;
      $display("FAIL reset_midpress: got e=%b cnt=%0d hex=%h%h%h%h, want 1 0 7f x4",
               empty, count, dataHex0, dataHex1, dataHex2, dataHex3);
    end
    @(negedge clock); reset_n = 1'b1;
    repeat (20) @(negedge clock);
    vectors++;
    if (count !== 4'd0 || empty !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_held_release: got cnt=%0d e=%b, want 0 1", count, empty);
    end
    button = 1'b1;
    repeat (PRESS_HI + 4) @(negedge clock);
  endtask

  task automatic test_fill();
    for (int i = 1; i <= 8; i++) begin
      press(1'b1, 16'(i), PRESS_LO);
      vectors++;
      if (count !== exp_count() || almostFull !== (i >= 6) || full !== (i == 8) || dataOut !== 16'h0001) begin
        miscompares++;
        $display("FAIL fill_%0d: got cnt=%0d af=%b f=%b do=%h, want %0d %b %b 0001",
                 i, count, almostFull, full, dataOut, exp_count(), (i >= 6), (i == 8));
      end
    end
    vectors++;
    if (dataHex0 !== 7'h79 || dataHex1 !== 7'h40) begin
      miscompares++;
      $display("FAIL fill_hex: got hex0=%h hex1=%h, want 79 40", dataHex0, dataHex1);
    end
  endtask

  task automatic test_overflow();
    press(1'b1, 16'h0007, PRESS_LO);
    vectors++;
    if (count !== 4'd8 || overflow !== 1'b1 || dataOut !== 16'h0001 || full !== 1'b1) begin
      miscompares++;
      $display("FAIL overflow: got cnt=%0d ov=%b do=%h f=%b, want 8 1 0001 1", count, overflow, dataOut, full);
    end
  endtask

  task automatic test_drain();
    for (int i = 1; i <= 8; i++) begin
      press(1'b0, 16'hFFFF, PRESS_LO);
      vectors++;
      if (dataOut !== exp_data() || count !== exp_count() || empty !== (i == 8) || almostEmpty !== (i >= 6)
          || dataHex0 !== exp_hex(0)) begin
        miscompares++;
        $display("FAIL drain_%0d: got do=%h cnt=%0d e=%b ae=%b hex0=%h, want %h %0d %b %b %h",
                 i, dataOut, count, empty, almostEmpty, dataHex0, exp_data(), exp_count(), (i == 8), (i >= 6), exp_hex(0));
      end
    end
  endtask

  task automatic test_underflow();
    press(1'b0, 16'h0, PRESS_LO);
    vectors++;
    if (underflow !== 1'b1 || count !== 4'd0 || empty !== 1'b1 || dataOut !== 16'h0) begin
      miscompares++;
      $display("FAIL underflow: got un=%b cnt=%0d e=%b do=%h, want 1 0 1 0000", underflow, count, empty, dataOut);
    end
  endtask

  task automatic test_held_wrap();
    logic [15:0] d;
    press(1'b1, 16'hBEEF, 20);
    vectors++;
    if (count !== 4'd1 || dataOut !== 16'hBEEF) begin
      miscompares++;
      $display("FAIL held_press: got cnt=%0d do=%h, want 1 beef", count, dataOut);
    end
    for (int i = 0; i < 12; i++) begin
      d = 16'($urandom);
      press(1'b1, d, PRESS_LO);
      press(1'b0, 16'h0, PRESS_LO);
      vectors++;
      if (count !== exp_count() || dataOut !== exp_data() || dataHex3 !== exp_hex(3)) begin
        miscompares++;
        $display("FAIL wrap_pair_%0d: got cnt=%0d do=%h hex3=%h, want %0d %h %h",
                 i, count, dataOut, dataHex3, exp_count(), exp_data(), exp_hex(3));
      end
    end
  endtask

  task automatic test_random();
    logic wr;
    for (int i = 0; i < 30; i++) begin
      wr = 1'($urandom_range(0, 1));
      press(wr, 16'($urandom), PRESS_LO);
      vectors++;
      if (count !== exp_count() || dataOut !== exp_data() || full !== (q.size() == 8) || empty !== (q.size() == 0)
          || almostFull !== (q.size() >= 6) || almostEmpty !== (q.size() <= 2)
          || overflow !== m_ovf || underflow !== m_unf
          || {dataHex0, dataHex1, dataHex2, dataHex3} !== {exp_hex(0), exp_hex(1), exp_hex(2), exp_hex(3)}) begin
        miscompares++;
        $display("FAIL random_%0d: got cnt=%0d do=%h f=%b e=%b af=%b ae=%b ov=%b un=%b, want %0d %h ov=%b un=%b",
                 i, count, dataOut, full, empty, almostFull, almostEmpty, overflow, underflow,
                 exp_count(), exp_data(), m_ovf, m_unf);
      end
    end
  endtask

`ifdef FIFO_DEBOUNCE_EN
  task automatic test_debounce();
    logic [3:0] before;
    before = exp_count();
    wren = 1'b1; dataIn = 16'h1234; button = 1'b0;
    repeat (3) @(negedge clock);
    button = 1'b1;
    repeat (12) @(negedge clock);
    vectors++;
    if (count !== before) begin
      miscompares++;
      $display("FAIL debounce_glitch: got cnt=%0d, want %0d", count, before);
    end
    button = 1'b0;
    repeat (6) @(negedge clock);
    button = 1'b1;
    vectors++;
    if (count !== before) begin
      miscompares++;
      $display("FAIL debounce_early: got cnt=%0d after edge 6, want %0d", count, before);
    end
    @(negedge clock);
    model_apply(1'b1, 16'h1234);
    vectors++;
    if (count !== exp_count()) begin
      miscompares++;
      $display("FAIL debounce_commit: got cnt=%0d after edge 7, want %0d", count, exp_count());
    end
    repeat (12) @(negedge clock);
  endtask
`endif

  initial begin
    test_reset();
    test_fill();
    test_overflow();
    test_drain();
    test_underflow();
    test_held_wrap();
`ifdef FIFO_DEBOUNCE_EN
    test_debounce();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
